vend_ctrl: RTL and testbench
============================

VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have parameter PRICE, default 6, item price in CNY (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 1000, idle cycles in COLLECT before automatic refund (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports i_one_cny / i_two_cny / i_five_cny  input  1 each  one-cycle coin-accepted pulses.
REQ-006 SHALL have port i_cancel  input  1  one-cycle customer cancel pulse.
REQ-007 SHALL have port i_coin_ack  input  1  hopper has dispensed the coin currently requested.
REQ-008 SHALL have port o_done  output  1  one-cycle vend pulse.
REQ-009 SHALL have port o_credit  output  5  current accumulated credit in CNY.
REQ-010 SHALL have port o_coin_req  output  1  request to hopper to dispense one coin.
REQ-011 SHALL have port o_coin_val  output  2  value of requested coin, 1 or 2 CNY.
REQ-012 SHALL have port o_busy  output  1  high in VEND and PAYOUT; coins are not accepted.

Function
REQ-013 SHALL implement FSM states IDLE, COLLECT, VEND, PAYOUT.
REQ-014 IDLE: any coin pulse SHALL add the coin value to credit and go to COLLECT; i_cancel SHALL be ignored.
REQ-015 Simultaneous coin pulses in one cycle SHALL all be credited (sum 1+2+5, max 8 per cycle).
REQ-016 COLLECT: coins SHALL accumulate; when the updated credit >= PRICE the next state SHALL be VEND.
REQ-017 COLLECT: i_cancel, or the idle counter reaching TIMEOUT, SHALL load remaining = credit (including a coin arriving that cycle) and go to PAYOUT.
REQ-018 Credit reaching PRICE in the same cycle as i_cancel or timeout SHALL take VEND (vend wins).
REQ-019 Idle counter (16 bit) SHALL clear on entry to COLLECT and on every coin pulse, increment otherwise, and saturate.
REQ-020 VEND SHALL last exactly one cycle with o_done=1, loading remaining = credit - PRICE; next state PAYOUT if remaining > 0, else IDLE.
REQ-021 PAYOUT: o_coin_req=1 with o_coin_val=2 while remaining >= 2, else 1; o_coin_val SHALL stay stable until acknowledged.
REQ-022 On i_coin_ack while o_coin_req=1, remaining SHALL decrease by o_coin_val; when this makes remaining 0, the next state SHALL be IDLE with o_coin_req low.
REQ-023 i_coin_ack while o_coin_req=0 SHALL be ignored.
REQ-024 Coin pulses and i_cancel in VEND or PAYOUT SHALL be ignored (not credited).
REQ-025 o_credit SHALL show accumulated credit in COLLECT, remaining in PAYOUT, and 0 in IDLE and after VEND.
REQ-026 Credit and remaining SHALL be 5 bits; the maximum credit is PRICE-1+8, so no overflow is possible for PRICE <= 15.

Reset
REQ-027 On rst=0 at a clock edge: state=IDLE, credit=0, remaining=0, idle counter=0, o_done=0, o_coin_req=0, o_coin_val=0, o_busy=0, o_credit=0.
REQ-028 Reset mid-PAYOUT SHALL abandon the outstanding payout and drop o_coin_req in the same cycle; any later i_coin_ack SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold the state encoding (4 states, 2 bits), coin values (1, 2, 5) and the default PRICE.
REQ-030 The payout sequencer (remaining, coin select, req/ack) SHALL be a sub-module named vend_payout; the FSM, credit and timeout logic SHALL stay in vend_ctrl.

Verification
REQ-031 Coins 5 then 1 (PRICE=6) -> o_done pulse 1 cycle after the second coin, no o_coin_req, return to IDLE.
REQ-032 Coins 5, 5 -> o_done, then PAYOUT of remaining 4: two requests with o_coin_val=2, each held until ack; o_credit goes 4 -> 2 -> 0.
REQ-033 Coin 2, then i_cancel with i_one_cny in the same cycle -> refund of 3: one coin of 2 then one coin of 1, no o_done.
REQ-034 TIMEOUT=10, coin 1, no further input -> PAYOUT entered exactly 10 cycles after the coin; one coin of 1 refunded.
REQ-035 Coin 5 with i_cancel and i_one_cny in the same cycle -> VEND wins, o_done asserted, no refund.
REQ-036 rst asserted during PAYOUT with ack delayed -> o_coin_req low the next cycle, state IDLE, late ack ignored, o_credit=0.

Source files
------------

// File: rtl/vend_ctrl_pkg.sv
// Shared definitions for the vending controller: state encoding, coin values,
// default parameters and a helper that sums the coin pulses seen in one cycle.
package vend_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_PAYOUT  = 2'd3
    } state_t;

    localparam logic [3:0] COIN_ONE_VAL  = 4'd1;
    localparam logic [3:0] COIN_TWO_VAL  = 4'd2;
    localparam logic [3:0] COIN_FIVE_VAL = 4'd5;

    localparam int unsigned DEFAULT_PRICE   = 6;
    localparam int unsigned DEFAULT_TIMEOUT = 1000;

    // Total value of all coins accepted in one cycle (0..8).
    function automatic logic [3:0] coin_sum(input logic one, input logic two, input logic five);
        coin_sum = (one  ? COIN_ONE_VAL  : 4'd0)
                 + (two  ? COIN_TWO_VAL  : 4'd0)
                 + (five ? COIN_FIVE_VAL : 4'd0);
    endfunction

endpackage

// File: rtl/vend_payout.sv
// Payout sequencer: holds the amount still owed to the customer and requests
// 2 CNY coins from the hopper while at least 2 remains, then 1 CNY coins.
module vend_payout (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_active,
    input  logic       i_load,
    input  logic [4:0] i_load_val,
    input  logic       i_coin_ack,
    output logic [4:0] o_remaining,
    output logic       o_coin_req,
    output logic [1:0] o_coin_val,
    output logic       o_last
);

    logic [4:0] r_remaining;
    logic [1:0] w_sel;
    logic       w_take;

    // Coin selection depends only on the registered remainder, so it stays
    // stable until the hopper acknowledges.
    always_comb begin
        w_sel       = (r_remaining >= 5'd2) ? 2'd2 : 2'd1;
        o_coin_req  = i_active && (r_remaining != 5'd0);
        o_coin_val  = o_coin_req ? w_sel : 2'd0;
        w_take      = o_coin_req && i_coin_ack;
        o_last      = w_take && (r_remaining == {3'b000, w_sel});
        o_remaining = r_remaining;
    end

    // Remainder register: load from the controller, decrement on each accepted ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_remaining <= '0;
        end else if (i_load) begin
            r_remaining <= i_load_val;
        end else if (w_take) begin
            r_remaining <= r_remaining - {3'b000, w_sel};
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: collects coins, vends when credit reaches PRICE, and
// refunds change or cancelled/timed-out credit through the payout sequencer.
module vend_ctrl
    import vend_ctrl_pkg::*;
#(
    parameter int unsigned PRICE   = DEFAULT_PRICE,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_one_cny,
    input  logic       i_two_cny,
    input  logic       i_five_cny,
    input  logic       i_cancel,
    input  logic       i_coin_ack,
    output logic       o_done,
    output logic [4:0] o_credit,
    output logic       o_coin_req,
    output logic [1:0] o_coin_val,
    output logic       o_busy
);

    localparam logic [4:0]  PRICE_V    = 5'(PRICE);
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    state_t      r_state, w_state_n;
    logic [4:0]  r_credit, w_credit_n;
    logic [15:0] r_idle, w_idle_n;

    logic [3:0]  w_sum;
    logic        w_coin;
    logic [4:0]  w_new_credit;
    logic        w_timeout;
    logic        w_load;
    logic [4:0]  w_load_val;
    logic [4:0]  w_remaining;
    logic        w_last;

    vend_payout u_payout (
        .clk         (clk),
        .rst         (rst),
        .i_active    (r_state == S_PAYOUT),
        .i_load      (w_load),
        .i_load_val  (w_load_val),
        .i_coin_ack  (i_coin_ack),
        .o_remaining (w_remaining),
        .o_coin_req  (o_coin_req),
        .o_coin_val  (o_coin_val),
        .o_last      (w_last)
    );

    // Next-state, credit/idle-counter update and Moore outputs.
    always_comb begin
        w_sum        = coin_sum(i_one_cny, i_two_cny, i_five_cny);
        w_coin       = i_one_cny | i_two_cny | i_five_cny;
        w_new_credit = r_credit + {1'b0, w_sum};
        // Comparing the pre-increment count against TIMEOUT-1 fires on the
        // cycle the counter reaches TIMEOUT, without a 17-bit compare.
        w_timeout    = !w_coin && (r_idle >= TIMEOUT_M1);

        w_state_n  = r_state;
        w_credit_n = r_credit;
        w_idle_n   = '0;
        w_load     = 1'b0;
        w_load_val = '0;
        o_done     = 1'b0;
        o_busy     = 1'b0;
        o_credit   = '0;

        case (r_state)
            S_IDLE: begin
                w_credit_n = '0;
                if (w_coin) begin
                    w_credit_n = {1'b0, w_sum};
                    w_state_n  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                o_credit   = r_credit;
                w_credit_n = w_new_credit;
                w_idle_n   = w_coin ? 16'd0 : ((r_idle == 16'hFFFF) ? r_idle : r_idle + 16'd1);
                if (w_new_credit >= PRICE_V) begin
                    w_state_n = S_VEND;
                end else if (i_cancel || w_timeout) begin
                    w_load     = 1'b1;
                    w_load_val = w_new_credit;
                    w_credit_n = '0;
                    w_state_n  = S_PAYOUT;
                end
            end
            S_VEND: begin
                o_done     = 1'b1;
                o_busy     = 1'b1;
                w_load     = 1'b1;
                w_load_val = r_credit - PRICE_V;
                w_credit_n = '0;
                w_state_n  = (r_credit != PRICE_V) ? S_PAYOUT : S_IDLE;
            end
            S_PAYOUT: begin
                o_busy   = 1'b1;
                o_credit = w_remaining;
                if (w_last) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n  = S_IDLE;
                w_credit_n = '0;
            end
        endcase
    end

    // State, credit and idle-counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_idle   <= '0;
        end else begin
            r_state  <= w_state_n;
            r_credit <= w_credit_n;
            r_idle   <= w_idle_n;
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed testbench for vend_ctrl (PRICE=6, TIMEOUT=10).
module tb_vend_ctrl;

    logic       clk;
    logic       rst;
    logic       i_one_cny, i_two_cny, i_five_cny, i_cancel, i_coin_ack;
    logic       o_done;
    logic [4:0] o_credit;
    logic       o_coin_req;
    logic [1:0] o_coin_val;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;

    vend_ctrl #(.PRICE(6), .TIMEOUT(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_one_cny  (i_one_cny),
        .i_two_cny  (i_two_cny),
        .i_five_cny (i_five_cny),
        .i_cancel   (i_cancel),
        .i_coin_ack (i_coin_ack),
        .o_done     (o_done),
        .o_credit   (o_credit),
        .o_coin_req (o_coin_req),
        .o_coin_val (o_coin_val),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic e_done, input logic [4:0] e_credit,
                           input logic e_req, input logic [1:0] e_val, input logic e_busy);
        chk({tag, ".done"},   {7'd0, o_done},     {7'd0, e_done});
        chk({tag, ".credit"}, {3'd0, o_credit},   {3'd0, e_credit});
        chk({tag, ".req"},    {7'd0, o_coin_req}, {7'd0, e_req});
        chk({tag, ".val"},    {6'd0, o_coin_val}, {6'd0, e_val});
        chk({tag, ".busy"},   {7'd0, o_busy},     {7'd0, e_busy});
    endtask

    // Apply inputs for one clock edge, then sample 1 time unit after it.
    task automatic cyc(input logic one, input logic two, input logic five,
                       input logic cancel, input logic ack);
        i_one_cny  = one;
        i_two_cny  = two;
        i_five_cny = five;
        i_cancel   = cancel;
        i_coin_ack = ack;
        @(posedge clk);
        #1;
        i_one_cny  = 1'b0;
        i_two_cny  = 1'b0;
        i_five_cny = 1'b0;
        i_cancel   = 1'b0;
        i_coin_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        i_one_cny = 1'b0; i_two_cny = 1'b0; i_five_cny = 1'b0;
        i_cancel = 1'b0; i_coin_ack = 1'b0;

        // Reset, with a coin pulse that must be ignored
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        exp_out("reset", 0, 0, 0, 0, 0);
        rst = 1'b1;

        // IDLE ignores cancel and ack
        cyc(0, 0, 0, 1, 0);
        exp_out("idle_cancel", 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        exp_out("idle_ack", 0, 0, 0, 0, 0);

        // 5 then 1: exact price
        cyc(0, 0, 1, 0, 0);
        exp_out("t1_c5", 0, 5, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        exp_out("t1_vend", 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        exp_out("t1_idle", 0, 0, 0, 0, 0);

        // 5, 5: change of 4 as two 2s; coins in VEND/PAYOUT ignored
        cyc(0, 0, 1, 0, 0);
        exp_out("t2_c5", 0, 5, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        exp_out("t2_vend", 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 1, 0);
        exp_out("t2_pay4", 0, 4, 1, 2, 1);
        cyc(0, 0, 1, 1, 0);
        exp_out("t2_hold4", 0, 4, 1, 2, 1);
        cyc(0, 0, 0, 0, 1);
        exp_out("t2_pay2", 0, 2, 1, 2, 1);
        cyc(0, 0, 0, 0, 0);
        exp_out("t2_hold2", 0, 2, 1, 2, 1);
        cyc(0, 0, 0, 0, 1);
        exp_out("t2_idle", 0, 0, 0, 0, 0);

        // 2, then cancel with a 1 in the same cycle: refund 3 as 2 + 1
        cyc(0, 1, 0, 0, 0);
        exp_out("t3_c2", 0, 2, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        exp_out("t3_pay3", 0, 3, 1, 2, 1);
        cyc(0, 0, 0, 0, 1);
        exp_out("t3_pay1", 0, 1, 1, 1, 1);
        cyc(0, 0, 0, 0, 1);
        exp_out("t3_idle", 0, 0, 0, 0, 0);

        // Timeout: coin 1, PAYOUT exactly 10 cycles later
        cyc(1, 0, 0, 0, 0);
        exp_out("t4_c1", 0, 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            cyc(0, 0, 0, 0, 0);
            exp_out($sformatf("t4_wait%0d", i), 0, 1, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0);
        exp_out("t4_pay1", 0, 1, 1, 1, 1);
        cyc(0, 0, 0, 0, 1);
        exp_out("t4_idle", 0, 0, 0, 0, 0);

        // A coin restarts the idle count
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        exp_out("t4b_c2", 0, 2, 0, 0, 0);
        for (int i = 1; i <= 9; i++) cyc(0, 0, 0, 0, 0);
        exp_out("t4b_wait9", 0, 2, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        exp_out("t4b_pay2", 0, 2, 1, 2, 1);
        cyc(0, 0, 0, 0, 1);
        exp_out("t4b_idle", 0, 0, 0, 0, 0);

        // 5 + 1 + cancel from IDLE: credit 6, vend, no refund
        cyc(1, 0, 1, 1, 0);
        exp_out("t5_c6", 0, 6, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        exp_out("t5_vend", 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        exp_out("t5_idle", 0, 0, 0, 0, 0);

        // In COLLECT: price reached together with cancel -> vend wins
        cyc(1, 0, 0, 0, 0);
        exp_out("t6_c1", 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        exp_out("t6_vend", 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        exp_out("t6_idle", 0, 0, 0, 0, 0);

        // All three coins at once: credit 8, change 2
        cyc(1, 1, 1, 0, 0);
        exp_out("t7_c8", 0, 8, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        exp_out("t7_vend", 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        exp_out("t7_pay2", 0, 2, 1, 2, 1);
        cyc(0, 0, 0, 0, 1);
        exp_out("t7_idle", 0, 0, 0, 0, 0);

        // Reset during PAYOUT, then late ack ignored
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        exp_out("t8_pay4", 0, 4, 1, 2, 1);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
        exp_out("t8_rst", 0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 1);
        exp_out("t8_lateack", 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        exp_out("t8_c1", 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        exp_out("t8_pay1", 0, 1, 1, 1, 1);
        cyc(0, 0, 0, 0, 1);
        exp_out("t8_idle", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
